load_store_unit: RTL

- Parametrised, sequential successor to the combinational memory-access stage; sits between execute and the data memory port.
- Accepts one load/store request per valid/ready handshake and computes the effective address.
- Drives a req/gnt/rvalid memory interface with byte enables and lane placement, and returns sign/zero-extended load data with an error code.
- One transaction in flight; the unit is a 4-state FSM.

---
 rtl/load_store_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, req/gnt/rvalid memory port, lane placement and load extension.
// Optional transaction timeout is compiled in with LSU_TIMEOUT_EN.

module lsu_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int LSB        = 2,
    parameter int LANE       = 0
) (
    input  logic [LSB-1:0]        off_i,
    input  logic [1:0]            size_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  be_o,
    output logic [7:0]            byte_o
);
    logic [3:0] nbytes;
    logic [4:0] lane_c, lo, hi;
    logic [2:0] sel;

    assign nbytes = 4'd1 << size_i;
    assign lane_c = 5'(LANE);
    assign lo     = 5'(off_i);
    assign hi     = 5'(off_i) + 5'(nbytes);
    assign be_o   = (lane_c >= lo) && (lane_c < hi);
    // Replication: lane LANE carries datum byte (LANE mod access size).
    assign sel    = 3'(LANE) & 3'(nbytes - 4'd1);
    assign byte_o = wdata_i[{sel, 3'b000} +: 8];
endmodule

module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int NB            = DATA_WIDTH / 8,
    localparam int LSB           = $clog2(NB)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  store_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] rs1_data_i,
    input  logic [ADDR_WIDTH-1:0] offset_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [NB-1:0]         mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [1:0]            err_code_o
);
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("load_store_unit: unsupported parameters");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                  store;
        logic [1:0]            size;
        logic                  uns;
        logic [ADDR_WIDTH-1:0] ea;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    localparam logic [1:0] ERR_OK = 2'b00, ERR_MIS = 2'b01, ERR_TO = 2'b10, ERR_ILL = 2'b11;

    state_t                state_q, state_d;
    req_t                  req_q, req_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [1:0]            err_q, err_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;
    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    logic [ADDR_WIDTH-1:0] ea;
    logic                  illegal, misaligned, iss;
    assign ea         = rs1_data_i + offset_i;
    assign illegal    = (DATA_WIDTH == 32) && (size_i == 2'd3);
    assign misaligned = |(ea[2:0] & ~(3'b111 << size_i));

    logic [NB-1:0]       be_l;
    logic [NB-1:0][7:0]  wbytes;
    for (genvar i = 0; i < NB; i++) begin : g_lane
        lsu_lane #(.DATA_WIDTH(DATA_WIDTH), .LSB(LSB), .LANE(i)) u_lane (
            .off_i  (req_q.ea[LSB-1:0]),
            .size_i (req_q.size),
            .wdata_i(req_q.wdata),
            .be_o   (be_l[i]),
            .byte_o (wbytes[i])
        );
    end

    // Load extraction: align the addressed bytes to bit 0, then mask and extend.
    logic [DATA_WIDTH-1:0] sh, mask, ext;
    logic [6:0]            nbits;
    logic                  sgn;
    always_comb begin
        sh    = mem_rdata_i >> {req_q.ea[LSB-1:0], 3'b000};
        nbits = 7'd8 << req_q.size;
        mask  = ~({DATA_WIDTH{1'b1}} << nbits);
        case (req_q.size)
            2'd0:    sgn = sh[7];
            2'd1:    sgn = sh[15];
            2'd2:    sgn = sh[31];
            default: sgn = sh[DATA_WIDTH-1];
        endcase
        ext = (sh & mask) | ((sgn && !req_q.uns) ? ~mask : '0);
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rd_d    = rd_q;
        err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (req_valid_i) begin
                req_d = '{store: store_i, size: size_i, uns: unsigned_i, ea: ea, wdata: rs2_data_i};
                rd_d  = '0;
                err_d = ERR_OK;
`ifdef LSU_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (illegal) begin
                    err_d   = ERR_ILL;
                    state_d = RESP;
                end else if (misaligned) begin
                    err_d   = ERR_MIS;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (mem_gnt_i) begin
                    state_d = req_q.store ? RESP : WAIT;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo) begin
                    err_d   = ERR_TO;
                    state_d = RESP;
                end
`endif
            end
            WAIT: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (mem_rvalid_i) begin
                    rd_d    = ext;
                    state_d = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo) begin
                    err_d   = ERR_TO;
                    rd_d    = '0;
                    state_d = RESP;
                end
`endif
            end
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            rd_q    <= '0;
            err_q   <= ERR_OK;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign iss         = (state_q == ISSUE);
    assign req_ready_o = rst_ni && (state_q == IDLE);
    assign mem_req_o   = iss;
    assign mem_we_o    = iss && req_q.store;
    assign mem_addr_o  = iss ? {req_q.ea[ADDR_WIDTH-1:LSB], {LSB{1'b0}}} : '0;
    assign mem_be_o    = iss ? be_l : '0;
    assign mem_wdata_o = iss ? wbytes : '0;
    assign rsp_valid_o = (state_q == RESP);
    assign rd_data_o   = rd_q;
    assign err_code_o  = err_q;
endmodule
